// File: rtl/bcd_counter_pkg.sv
// Shared constants and helpers for the multi-digit BCD counter.
// Imported by bcd_digit and bcd_counter_nd.
package bcd_counter_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

  // A nibble above 9 is not a legal BCD digit.
  function automatic logic bcd_invalid(input logic [DIGIT_W-1:0] nib);
    return nib > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: load has priority over increment/decrement.
// Increment wraps 9->0 and decrement wraps 0->9; the parent decides when to step.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic               CLK,
  input  logic               RESN,
  input  logic               inc,
  input  logic               dec,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  output logic [DIGIT_W-1:0] q,
  output logic               at9,
  output logic               at0
);

  always_ff @(posedge CLK) begin
    if (!RESN) begin
      q <= BCD_MIN;
    end else if (ld) begin
      q <= ld_val;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
    end else if (dec) begin
      q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
    end
  end

  assign at9 = (q == BCD_MAX);
  assign at0 = (q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_nd.sv
// DIGITS-wide BCD up/down counter with validated parallel load.
// Carry/borrow ripples combinationally so every digit updates on the same edge.
module bcd_counter_nd
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RESN,
  input  logic                    EN,
  input  logic                    UP,
  input  logic                    LOAD,
  input  logic [DIGIT_W*DIGITS-1:0] LOAD_VAL,
  output logic [DIGIT_W*DIGITS-1:0] countVal,
  output logic                    TC,
  output logic                    WRAP,
  output logic                    LOAD_ERR
);

  logic [DIGITS-1:0] at9;
  logic [DIGITS-1:0] at0;
  logic [DIGITS-1:0] inc;
  logic [DIGITS-1:0] dec;
  // low9[k]/low0[k]: every digit below k is at 9 / at 0.
  logic [DIGITS:0]   low9;
  logic [DIGITS:0]   low0;
  logic              load_bad;
  logic              load_ok;
  logic              at_limit;
  logic              count_go;

  always_comb begin
    load_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      load_bad = load_bad | bcd_invalid(LOAD_VAL[k*DIGIT_W +: DIGIT_W]);
    end
  end

  assign low9[0] = 1'b1;
  assign low0[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign low9[k+1] = low9[k] & at9[k];
    assign low0[k+1] = low0[k] & at0[k];
    assign inc[k]    = count_go & UP & low9[k];
    assign dec[k]    = count_go & ~UP & low0[k];

    bcd_digit u_digit (
      .CLK    (CLK),
      .RESN   (RESN),
      .inc    (inc[k]),
      .dec    (dec[k]),
      .ld     (load_ok),
      .ld_val (LOAD_VAL[k*DIGIT_W +: DIGIT_W]),
      .q      (countVal[k*DIGIT_W +: DIGIT_W]),
      .at9    (at9[k]),
      .at0    (at0[k])
    );
  end

  assign load_ok  = LOAD & ~load_bad;
  assign at_limit = UP ? low9[DIGITS] : low0[DIGITS];
  // Any load request, good or bad, suppresses counting that cycle.
  assign count_go = EN & ~LOAD & ~(SATURATE & at_limit);
  assign TC       = EN & at_limit;

  always_ff @(posedge CLK) begin
    if (!RESN) begin
      WRAP     <= 1'b0;
      LOAD_ERR <= 1'b0;
    end else begin
      WRAP     <= count_go & at_limit;
      LOAD_ERR <= LOAD & load_bad;
    end
  end

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Bench for bcd_counter_nd: four instances (1, 4, 8 digits wrapping; 4 digits saturating)
// share stimulus and are compared against a decimal-integer reference model.
module tb_bcd_counter_nd;

  localparam int N_DUT  = 4;
  localparam int N_RAND = 10000;
  localparam int W      = 32;

  logic          clk;
  logic          resn;
  logic          en;
  logic          up;
  logic          load;
  logic [31:0]   load_val;

  logic [3:0]    cv1;
  logic [15:0]   cv4;
  logic [31:0]   cv8;
  logic [15:0]   cv4s;
  logic [31:0]   cv   [N_DUT];
  logic          tc   [N_DUT];
  logic          wrap [N_DUT];
  logic          lerr [N_DUT];

  int            md [N_DUT] = '{1, 4, 8, 4};
  bit            ms [N_DUT] = '{1'b0, 1'b0, 1'b0, 1'b1};

  // reference model state: plain decimal value per instance
  longint        mv [N_DUT];
  logic          mw [N_DUT];
  logic          me [N_DUT];
  bit            model_ok;

  logic [W-1:0]  exp_q[$];
  int            n_checks;
  int            n_errors;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  bcd_counter_nd #(.DIGITS(1), .SATURATE(1'b0)) u_dut1 (
    .CLK(clk), .RESN(resn), .EN(en), .UP(up), .LOAD(load), .LOAD_VAL(load_val[3:0]),
    .countVal(cv1), .TC(tc[0]), .WRAP(wrap[0]), .LOAD_ERR(lerr[0]));

  bcd_counter_nd #(.DIGITS(4), .SATURATE(1'b0)) u_dut4 (
    .CLK(clk), .RESN(resn), .EN(en), .UP(up), .LOAD(load), .LOAD_VAL(load_val[15:0]),
    .countVal(cv4), .TC(tc[1]), .WRAP(wrap[1]), .LOAD_ERR(lerr[1]));

  bcd_counter_nd #(.DIGITS(8), .SATURATE(1'b0)) u_dut8 (
    .CLK(clk), .RESN(resn), .EN(en), .UP(up), .LOAD(load), .LOAD_VAL(load_val),
    .countVal(cv8), .TC(tc[2]), .WRAP(wrap[2]), .LOAD_ERR(lerr[2]));

  bcd_counter_nd #(.DIGITS(4), .SATURATE(1'b1)) u_dut4s (
    .CLK(clk), .RESN(resn), .EN(en), .UP(up), .LOAD(load), .LOAD_VAL(load_val[15:0]),
    .countVal(cv4s), .TC(tc[3]), .WRAP(wrap[3]), .LOAD_ERR(lerr[3]));

  assign cv[0] = {28'd0, cv1};
  assign cv[1] = {16'd0, cv4};
  assign cv[2] = cv8;
  assign cv[3] = {16'd0, cv4s};

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint p10(input int d);
    longint r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input longint v, input int d);
    logic [31:0] r = '0;
    longint      t = v;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  task automatic model_next();
    for (int i = 0; i < N_DUT; i++) begin
      longint mx  = p10(md[i]) - 1;
      longint val = 0;
      bit     bad = 1'b0;
      mw[i] = 1'b0;
      me[i] = 1'b0;
      if (!resn) begin
        mv[i] = 0;
      end else if (load) begin
        for (int k = 0; k < md[i]; k++) begin
          logic [3:0] nib = load_val[4*k +: 4];
          if (nib > 4'd9) bad = 1'b1;
          val = val + longint'(nib) * p10(k);
        end
        if (bad) me[i] = 1'b1;
        else     mv[i] = val;
      end else if (en) begin
        if (up) begin
          if (mv[i] == mx) begin
            if (!ms[i]) begin mv[i] = 0; mw[i] = 1'b1; end
          end else begin
            mv[i] = mv[i] + 1;
          end
        end else begin
          if (mv[i] == 0) begin
            if (!ms[i]) begin mv[i] = mx; mw[i] = 1'b1; end
          end else begin
            mv[i] = mv[i] - 1;
          end
        end
      end
    end
    model_ok = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  // Apply inputs away from the edge, then check the combinational terminal count.
  task automatic drive(input logic resn_i, input logic en_i, input logic up_i,
                       input logic ld_i, input logic [31:0] lv_i);
    resn     = resn_i;
    en       = en_i;
    up       = up_i;
    load     = ld_i;
    load_val = lv_i;
    #1;
    if (model_ok) begin
      for (int i = 0; i < N_DUT; i++) begin
        logic exp_tc = en_i & (up_i ? (mv[i] == p10(md[i]) - 1) : (mv[i] == 0));
        check($sformatf("tc%0d", i), {31'd0, tc[i]}, {31'd0, exp_tc});
      end
    end
  endtask

  // Advance one edge and compare every instance with the model.
  task automatic tick();
    model_next();
    for (int i = 0; i < N_DUT; i++) exp_q.push_back(to_bcd(mv[i], md[i]));
    @(posedge clk);
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      logic [W-1:0] exp_cv = exp_q.pop_front();
      check($sformatf("cv%0d", i),   cv[i], exp_cv);
      check($sformatf("wrap%0d", i), {31'd0, wrap[i]}, {31'd0, mw[i]});
      check($sformatf("lerr%0d", i), {31'd0, lerr[i]}, {31'd0, me[i]});
      check($sformatf("excl%0d", i), {31'd0, wrap[i] & lerr[i]}, 32'd0);
      for (int k = 0; k < md[i]; k++) begin
        logic [3:0] nib = cv[i][4*k +: 4];
        check($sformatf("nib%0d_%0d", i, k), {31'd0, nib <= 4'd9}, 32'd1);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    model_ok = 1'b0;
    resn = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    @(posedge clk);
    #1;

    // reset overrides load and enable
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h1234);
    tick();
    check("rst_cv",   cv[1], 32'h0);
    check("rst_wrap", {31'd0, wrap[1]}, 32'd0);
    check("rst_lerr", {31'd0, lerr[1]}, 32'd0);

    // carry across two digits
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0099);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    check("carry_a", cv[1], 32'h0100);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    check("carry_b", cv[1], 32'h0101);
    check("carry_nowrap", {31'd0, wrap[1]}, 32'd0);

    // wrap up from all-9, then down from all-0
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h9999);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("tc_9999", {31'd0, tc[1]}, 32'd1);
    tick();
    check("wrap_up_cv", cv[1], 32'h0);
    check("wrap_up",    {31'd0, wrap[1]}, 32'd1);
    check("sat_hold9",  cv[3], 32'h9999);
    check("sat_nowrap", {31'd0, wrap[3]}, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    check("wrap_pulse1", {31'd0, wrap[1]}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    check("wrap_dn_cv", cv[1], 32'h9999);
    check("wrap_dn",    {31'd0, wrap[1]}, 32'd1);

    // saturating instance holds at zero going down
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    tick();
    repeat (3) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check("sat_tc", {31'd0, tc[3]}, 32'd1);
      tick();
      check("sat_cv0",  cv[3], 32'h0);
      check("sat_wrap", {31'd0, wrap[3]}, 32'd0);
    end

    // rejected load: hold, flag, no count
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h1234);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h12A4);
    tick();
    check("bad_ld_cv",   cv[1], 32'h1234);
    check("bad_ld_flag", {31'd0, lerr[1]}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    check("bad_ld_pulse", {31'd0, lerr[1]}, 32'd0);

    // reset mid-count, then count from zero
    repeat (3) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    check("midrst_cv", cv[1], 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    check("after_rst_cv", cv[1], 32'h1);

    // randomized run against the model
    for (int c = 0; c < N_RAND; c++) begin
      logic        r_resn = ($urandom_range(0, 199) != 0);
      logic        r_ld   = ($urandom_range(0, 9) == 0);
      logic        r_en   = ($urandom_range(0, 3) != 0);
      logic        r_up   = 1'($urandom_range(0, 1));
      logic [31:0] r_lv   = '0;
      case ($urandom_range(0, 3))
        0: r_lv = 32'h9999_9999;
        1: r_lv = 32'h0;
        2: for (int k = 0; k < 8; k++) r_lv[4*k +: 4] = 4'($urandom_range(0, 9));
        default: r_lv = $urandom;
      endcase
      drive(r_resn, r_en, r_up, r_ld, r_lv);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
